matrix_mult_seq_ctrl: RTL and testbench
=======================================

// Module: matrix_mult_seq_ctrl
// PURPOSE
//  Sequencer for a 32x10 fixed-point matrix-vector product y = A*x, using a single time-shared MAC.
//  A and x sit in external synchronous-read RAMs; this block issues their read addresses and runs the MAC pipeline.
//  It emits y one row at a time on a valid/ready stream.
//  It is the low-area serial alternative to the fully parallel combinational multiplier, for NN layer evaluation.
// PARAMETERS
//  ROWS    32  number of matrix rows (outputs)
//  COLS    10  number of matrix columns (inputs)
//  DW      32  data width, Q8.24 fixed point
//  AW       9  A address width, clog2(ROWS*COLS)
//  XW       4  x address width, clog2(COLS)
//  RW       5  row index width, clog2(ROWS)
// PORTS
//  clk      in   1   clock, rising edge
//  rst_n    in   1   synchronous active-low reset
//  start    in   1   begin a full product; sampled only in IDLE
//  busy     out  1   high from the cycle after start is accepted until done
//  done     out  1   1-cycle pulse after the last y row handshake
//  a_rd_en  out  1   A RAM read strobe
//  a_addr   out  AW  linear A address = row*COLS + col
//  a_data   in   DW  A[row][col], valid the cycle after a_rd_en
//  x_rd_en  out  1   x RAM read strobe, always equal to a_rd_en
//  x_addr   out  XW  x address = col
//  x_data   in   DW  x[col], valid the cycle after x_rd_en
//  y_data   out  DW  y[row] result
//  y_idx    out  RW  row index of y_data
//  y_valid  out  1   y_data/y_idx valid
//  y_ready  in   1   consumer accepts; handshake = y_valid & y_ready
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, row=col=0, accumulator=0, all outputs 0. This applies from any state; an in-flight job is abandoned and no done pulse is issued.
//  FSM states: IDLE -> ISSUE -> DRAIN -> OUT -> (ISSUE for the next row | IDLE).
//   IDLE:  on start=1, go to ISSUE with row=0, col=0.
//   ISSUE: one cycle per column.
//          - Drive a_rd_en=x_rd_en=1, a_addr=row*COLS+col, x_addr=col.
//          - col increments each cycle. After col=COLS-1, col returns to 0 and the FSM goes to DRAIN.
//   DRAIN: exactly 2 cycles, to flush the RAM-read and multiply stages.
//   OUT:   y_valid=1 with y_data and y_idx stable until the handshake.
//          - On handshake with row<ROWS-1: row++, go to ISSUE.
//          - On handshake with row=ROWS-1: go to IDLE and pulse done next cycle.
//  Outputs outside ISSUE and OUT: rd_en=0, addresses=0, y_valid=0.
//  MAC pipeline:
//   - Stage 1 registers the 64-bit unsigned product p = a_data*x_data in the cycle data is valid.
//   - Stage 2: acc = (first column of row ? 0 : acc) + p[55:24]. The sum wraps modulo 2^32 with no saturation.
//   - p bits [63:56] and [23:0] are discarded (Q8.24 rescale and truncation).
//  Timing (start sampled at edge 0, y_ready tied to 1):
//   - Row r ISSUE spans cycles 1+13r .. 10+13r; DRAIN spans 11+13r .. 12+13r; y_valid is high in cycle 13+13r.
//   - Row period is 13 cycles; done pulses in cycle 417 and busy falls in that same cycle.
//  Backpressure: while y_valid=1 and y_ready=0, the FSM holds in OUT, no reads are issued, and outputs are frozen.
//  start is ignored while busy=1. A start in the same cycle as done's IDLE entry is accepted the following cycle.
//  busy=1 in ISSUE, DRAIN and OUT; busy=0 in IDLE.
// TESTING
//  1. A all 0x01000000, x all 0x01000000, y_ready=1 -> 32 beats, y_idx 0..31, y_data=0x0A000000 each; done at cycle 417.
//  2. A[i][j]=i<<24, x all 0x00800000 (0.5) -> y_data for row i = i*0x05000000 (wraps mod 2^32 for i>=52 n/a; max 0x9B000000).
//  3. A all 0x10000000, x all 0x10000000 -> product bit 56 only -> y_data=0x00000000 for all rows (truncation check).
//  4. y_ready low for 5 cycles on row 3 -> y_data/y_idx=3 held, a_rd_en=0 throughout; total completion delayed by exactly 5 cycles.
//  5. rst_n=0 during row 7 ISSUE -> next cycle all outputs 0 and busy=0, no done pulse; new start gives correct full result.
//  6. start pulsed mid-job and in the same cycle as done -> mid-job pulse ignored; a start held one cycle later launches a new job.

Source files
------------

// File: rtl/matrix_mult_seq_ctrl.sv
// Serial matrix-vector product sequencer: walks A row by row through one
// time-shared MAC and streams y[row] out on a valid/ready interface.
module matrix_mult_seq_ctrl #(
    parameter int ROWS = 32,
    parameter int COLS = 10,
    parameter int DW   = 32,
    parameter int AW   = 9,
    parameter int XW   = 4,
    parameter int RW   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          a_rd_en,
    output logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          x_rd_en,
    output logic [XW-1:0] x_addr,
    input  logic [DW-1:0] x_data,
    output logic [DW-1:0] y_data,
    output logic [RW-1:0] y_idx,
    output logic          y_valid,
    input  logic          y_ready
);
    // Q8.24: keep product bits [FRAC+DW-1:FRAC]
    localparam int FRAC   = 24;
    // RAM read stage + multiply stage ahead of the accumulator
    localparam int STAGES = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    state_t          state, state_n;
    logic [RW-1:0]   row, row_n;
    logic [XW-1:0]   col, col_n;
    logic            dcnt, dcnt_n;
    logic            done_n;
    logic            first0;
    logic [STAGES:1] vld_pipe;
    logic [STAGES:1] first_pipe;
    logic [DW-1:0]   prod;
    logic [DW-1:0]   acc;

    assign busy    = (state != IDLE);
    assign x_rd_en = a_rd_en;

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
            dcnt  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            row   <= row_n;
            col   <= col_n;
            dcnt  <= dcnt_n;
            done  <= done_n;
        end
    end

    // Next-state and output decode; everything idles at zero outside ISSUE/OUT
    always_comb begin
        state_n = state;
        row_n   = row;
        col_n   = col;
        dcnt_n  = dcnt;
        done_n  = 1'b0;
        a_rd_en = 1'b0;
        a_addr  = '0;
        x_addr  = '0;
        y_valid = 1'b0;
        y_data  = '0;
        y_idx   = '0;
        first0  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = ISSUE;
                    row_n   = '0;
                    col_n   = '0;
                end
            end
            ISSUE: begin
                a_rd_en = 1'b1;
                a_addr  = AW'(int'(row) * COLS + int'(col));
                x_addr  = col;
                first0  = (col == '0);
                if (col == XW'(COLS - 1)) begin
                    col_n   = '0;
                    dcnt_n  = 1'b0;
                    state_n = DRAIN;
                end else begin
                    col_n = col + 1'b1;
                end
            end
            DRAIN: begin
                // two cycles: lets the last column clear read and multiply stages
                dcnt_n = ~dcnt;
                if (dcnt) state_n = OUT;
            end
            OUT: begin
                y_valid = 1'b1;
                y_data  = acc;
                y_idx   = row;
                if (y_ready) begin
                    if (row == RW'(ROWS - 1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        row_n   = row + 1'b1;
                        state_n = ISSUE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // MAC pipeline: read-valid tracking, rescaled product, accumulate
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
            prod       <= '0;
            acc        <= '0;
        end else begin
            vld_pipe   <= {vld_pipe[STAGES-1:1], a_rd_en};
            first_pipe <= {first_pipe[STAGES-1:1], first0};
            if (vld_pipe[1])
                prod <= DW'(((2*DW)'(a_data) * (2*DW)'(x_data)) >> FRAC);
            if (vld_pipe[2])
                acc <= (first_pipe[2] ? '0 : acc) + prod;
        end
    end
endmodule

// File: tb/tb_matrix_mult_seq_ctrl.sv
// Scoreboard bench for matrix_mult_seq_ctrl: RAM models, expected rows queued
// at start, popped on each y handshake.
module tb_matrix_mult_seq_ctrl;
    localparam int ROWS = 32;
    localparam int COLS = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        y_ready = 1'b1;
    logic [31:0] a_data = '0;
    logic [31:0] x_data = '0;
    logic        busy, done, a_rd_en, x_rd_en, y_valid;
    logic [8:0]  a_addr;
    logic [3:0]  x_addr;
    logic [31:0] y_data;
    logic [4:0]  y_idx;

    logic [31:0] a_mem [0:ROWS*COLS-1];
    logic [31:0] x_mem [0:COLS-1];

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int dc;

    matrix_mult_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_data(a_data),
        .x_rd_en(x_rd_en), .x_addr(x_addr), .x_data(x_data),
        .y_data(y_data), .y_idx(y_idx), .y_valid(y_valid), .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    // synchronous-read RAM models
    always @(posedge clk) begin
        if (a_rd_en) a_data <= a_mem[a_addr];
        if (x_rd_en) x_data <= x_mem[x_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard pop on every accepted beat
    always @(negedge clk) begin
        if (rst_n && y_valid && y_ready) begin
            if (q.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("y_idx", 64'(y_idx), 64'(e.idx));
                chk("y_data", 64'(y_data), 64'(e.data));
            end
        end
    end

    function automatic logic [31:0] model_row(input int i);
        logic [31:0] s;
        logic [63:0] p;
        s = '0;
        for (int j = 0; j < COLS; j++) begin
            p = {32'b0, a_mem[i*COLS+j]} * {32'b0, x_mem[j]};
            s = s + p[55:24];
        end
        return s;
    endfunction

    task automatic fill(input int kind);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                case (kind)
                    0: a_mem[i*COLS+j] = 32'h0100_0000;
                    1: a_mem[i*COLS+j] = 32'(i) << 24;
                    2: a_mem[i*COLS+j] = 32'h1000_0000;
                    default: a_mem[i*COLS+j] = $urandom;
                endcase
        for (int j = 0; j < COLS; j++)
            case (kind)
                0: x_mem[j] = 32'h0100_0000;
                1: x_mem[j] = 32'h0080_0000;
                2: x_mem[j] = 32'h1000_0000;
                default: x_mem[j] = $urandom;
            endcase
    endtask

    task automatic push_exp(input int kind);
        exp_t e;
        for (int i = 0; i < ROWS; i++) begin
            e.idx = 5'(i);
            case (kind)
                0: e.data = 32'h0A00_0000;
                1: e.data = 32'(i) * 32'h0500_0000;
                2: e.data = 32'h0;
                default: e.data = model_row(i);
            endcase
            q.push_back(e);
        end
    endtask

    // One full product; cycle 1 is the first cycle after the start edge.
    task automatic run_job(input int kind, input bit do_start, input int stall_row,
                           input int stall_len, input logic [31:0] stall_val,
                           input bit pulse_mid, input bit chain, output int done_cyc);
        int cyc;
        int stalls;
        if (do_start) begin
            push_exp(kind);
            start = 1'b1;
        end
        @(posedge clk); #1;
        start    = 1'b0;
        cyc      = 1;
        stalls   = 0;
        done_cyc = -1;
        while (done_cyc < 0 && cyc < 2000) begin
            if (cyc == 1)  chk("c1_issue", {busy, a_rd_en, x_rd_en, a_addr, x_addr}, {3'b111, 9'd0, 4'd0});
            if (cyc == 2)  chk("c2_addr", {a_addr, x_addr}, {9'd1, 4'd1});
            if (cyc == 11) chk("c11_drain", {busy, a_rd_en, y_valid}, 3'b100);
            if (cyc == 14) chk("c14_row1", {a_rd_en, a_addr, x_addr}, {1'b1, 9'd10, 4'd0});
            if (done) begin
                done_cyc = cyc;
                chk("done_busy", 64'(busy), 64'd0);
            end
            if (y_valid && y_idx == stall_row && stalls < stall_len) begin
                y_ready = 1'b0;
                stalls++;
                chk("stall_hold", {a_rd_en, y_idx, y_data}, {1'b0, 5'(stall_row), stall_val});
            end else begin
                y_ready = 1'b1;
            end
            start = (pulse_mid && cyc == 50) || (chain && (cyc == 416 || cyc == 417));
            if (chain && cyc == 416) push_exp(kind);
            if (done_cyc < 0) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
    endtask

    initial begin
        bit seen;
        // reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ctrl", {busy, done, y_valid, a_rd_en, x_rd_en}, 5'b0);
        chk("rst_data", {a_addr, x_addr, y_idx, y_data}, 64'd0);

        // 1: unit values
        fill(0);
        run_job(0, 1'b1, -1, 0, 32'h0, 1'b0, 1'b0, dc);
        chk("t1_done_cyc", 64'(dc), 64'd417);

        // 2: row-scaled A, x = 0.5
        fill(1);
        run_job(1, 1'b1, -1, 0, 32'h0, 1'b0, 1'b0, dc);
        chk("t2_done_cyc", 64'(dc), 64'd417);

        // 3: product lands in discarded bit 56
        fill(2);
        run_job(2, 1'b1, -1, 0, 32'h0, 1'b0, 1'b0, dc);
        chk("t3_done_cyc", 64'(dc), 64'd417);

        // 4: 5-cycle backpressure on row 3
        fill(0);
        run_job(0, 1'b1, 3, 5, 32'h0A00_0000, 1'b0, 1'b0, dc);
        chk("t4_done_cyc", 64'(dc), 64'd422);

        // 6: mid-job start ignored, start across done launches next job
        fill(3);
        run_job(3, 1'b1, -1, 0, 32'h0, 1'b1, 1'b1, dc);
        chk("t6a_done_cyc", 64'(dc), 64'd417);
        run_job(3, 1'b0, -1, 0, 32'h0, 1'b0, 1'b0, dc);
        chk("t6b_done_cyc", 64'(dc), 64'd417);

        // 5: reset during row 7 ISSUE
        fill(0);
        push_exp(0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 95; c++) begin
            @(posedge clk); #1;
        end
        chk("t5_row7_col3", {a_rd_en, a_addr}, {1'b1, 9'd73});
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t5_rst_ctrl", {busy, done, y_valid, a_rd_en, x_rd_en}, 5'b0);
        chk("t5_rst_data", {a_addr, x_addr, y_idx, y_data}, 64'd0);
        rst_n = 1'b1;
        q.delete();
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("t5_no_done", 64'(seen), 64'd0);
        run_job(0, 1'b1, -1, 0, 32'h0, 1'b0, 1'b0, dc);
        chk("t5_done_cyc", 64'(dc), 64'd417);

        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
